huff_table_loader: RTL and testbench

//  Sequences loading of the Huffman decode lookup table.
//  - On start: clears all table entries to 0.
//  - Accepts a stream of (character, code length, code path) entries over a valid/ready handshake.
//  - Hashes each entry to a table slot and issues one registered write per entry.
//  - Flags invalid lengths and slot collisions; reports done to the decoder control.

---
 rtl/huff_pkg.sv | 39 +++
 rtl/huff_hash.sv | 27 ++
 rtl/huff_table_loader.sv | 146 ++++++++++++++
 tb/tb_huff_table_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared types and sizing for the Huffman table loader and the decoder-side lookup.
package huff_pkg;

  localparam int TABLE_DEPTH = 256;
  localparam int ADDR_W      = $clog2(TABLE_DEPTH);
  localparam int CHAR_W      = 8;
  localparam int PATH_W      = 12;
  localparam int LEN_W       = 4;
  localparam int MAX_LEN     = 12;
  // Entry counter must hold 0..TABLE_DEPTH inclusive.
  localparam int CNT_W       = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEN  = 2'b01,
    ERR_COLL = 2'b10
  } err_code_t;

  // One registered table write.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [CHAR_W-1:0] data;
  } tbl_wr_t;

  // Legal code lengths are 1..MAX_LEN.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(MAX_LEN));
  endfunction

endpackage

// File: rtl/huff_hash.sv
// Maps (code length, code path) to a lookup-table slot. Short codes index the
// lower half directly; each longer length owns a progressively smaller block at
// the top of the table, indexed by the path's most significant bits.
module huff_hash
  import huff_pkg::*;
(
  input  logic [LEN_W-1:0]  length,
  input  logic [PATH_W-1:0] path,
  output logic [ADDR_W-1:0] addr,
  output logic              len_ok
);

  // Region select by length; blocks never overlap so the sums cannot wrap.
  always_comb begin
    len_ok = len_legal(length);
    addr   = {1'b0, path[6:0]};
    case (length)
      4'd8:    addr = 8'd128 + {2'b00, path[8:3]};
      4'd9:    addr = 8'd192 + {3'b000, path[9:5]};
      4'd10:   addr = 8'd224 + {4'b0000, path[10:7]};
      4'd11:   addr = 8'd240 + {5'b00000, path[11:9]};
      4'd12:   addr = 8'd248 + {6'b000000, path[11:10]};
      default: addr = {1'b0, path[6:0]};
    endcase
  end

endmodule

// File: rtl/huff_table_loader.sv
// Sequences a Huffman lookup-table load: wipe every slot, then accept entries
// over valid/ready, hash each to a slot and write it one cycle later. Bad
// lengths and slot collisions stop the load with an error code.
module huff_table_loader
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_entries,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic [LEN_W-1:0]  in_length,
  input  logic [PATH_W-1:0] in_path,
  output logic              tbl_we,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [CHAR_W-1:0] tbl_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  loader_state_t          state, state_nxt;
  err_code_t              err_q, err_nxt;
  tbl_wr_t                wr_q, wr_nxt;
  logic [CNT_W-1:0]       num_q, num_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic [TABLE_DEPTH-1:0] occ;
  logic                   occ_clr, occ_set;
  logic [ADDR_W-1:0]      hash_addr;
  logic                   hash_len_ok;
  logic                   accept;

  huff_hash u_hash (
    .length (in_length),
    .path   (in_path),
    .addr   (hash_addr),
    .len_ok (hash_len_ok)
  );

  // Ready only while entries remain; abort withdraws ready so a beat is never
  // considered taken in the cycle it is discarded.
  assign in_ready = (state == ST_LOAD) && (cnt_q < num_q) && !abort;
  assign accept   = in_valid && in_ready;

  // State, counters, pending write and error code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      err_q <= ERR_NONE;
      wr_q  <= '0;
      num_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      wr_q  <= wr_nxt;
      num_q <= num_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Occupancy bitmap: one bit per slot, set on each legal accept so the very
  // next beat already sees it.
  always_ff @(posedge clk) begin
    if (rst || occ_clr) begin
      occ <= '0;
    end else if (occ_set) begin
      occ[hash_addr] <= 1'b1;
    end
  end

  // Next-state, write issue and error capture.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    num_nxt   = num_q;
    cnt_nxt   = cnt_q;
    occ_clr   = 1'b0;
    occ_set   = 1'b0;
    // Address/data hold their last value; only the enable pulses.
    wr_nxt    = '{we: 1'b0, addr: wr_q.addr, data: wr_q.data};

    if (abort) begin
      state_nxt = ST_IDLE;
      err_nxt   = ERR_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_nxt = ST_CLEAR;
            err_nxt   = ERR_NONE;
            num_nxt   = num_entries;
            cnt_nxt   = '0;
            occ_clr   = 1'b1;
            // First wipe write goes out in the first CLEAR cycle.
            wr_nxt    = '{we: 1'b1, addr: '0, data: '0};
          end
        end

        ST_CLEAR: begin
          // The write register doubles as the wipe address counter.
          if (wr_q.addr == '1) begin
            state_nxt = (num_q == '0) ? ST_DONE : ST_LOAD;
          end else begin
            wr_nxt = '{we: 1'b1, addr: wr_q.addr + 1'b1, data: '0};
          end
        end

        ST_LOAD: begin
          if (accept) begin
            if (!hash_len_ok) begin
              state_nxt = ST_ERROR;
              err_nxt   = ERR_LEN;
            end else if (occ[hash_addr]) begin
              state_nxt = ST_ERROR;
              err_nxt   = ERR_COLL;
            end else begin
              occ_set = 1'b1;
              cnt_nxt = cnt_q + CNT_W'(1);
              wr_nxt  = '{we: 1'b1, addr: hash_addr, data: in_char};
              // Last entry's write trails into the first DONE cycle.
              if ((cnt_q + CNT_W'(1)) == num_q) begin
                state_nxt = ST_DONE;
              end
            end
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign tbl_we   = wr_q.we;
  assign tbl_addr = wr_q.addr;
  assign tbl_data = wr_q.data;
  assign busy     = (state == ST_CLEAR) || (state == ST_LOAD);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERROR);
  assign err_code = err_q;

endmodule

// File: tb/tb_huff_table_loader.sv
// Self-checking bench for huff_table_loader: directed table vectors, hand
// sequences for the multi-cycle corners, and random loads against a reference.
module tb_huff_table_loader;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [8:0]  num_entries;
  logic        in_valid, in_ready;
  logic [7:0]  in_char;
  logic [3:0]  in_length;
  logic [11:0] in_path;
  logic        tbl_we;
  logic [7:0]  tbl_addr, tbl_data;
  logic        busy, done, error;
  logic [1:0]  err_code;

  huff_table_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_entries(num_entries),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_length(in_length),
    .in_path(in_path), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ch;
    logic [3:0]  len;
    logic [11:0] path;
  } ent_t;

  typedef struct {
    logic [7:0]  ch;
    logic [3:0]  len;
    logic [11:0] path;
    logic [7:0]  exp_addr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        ents[$];
  logic [15:0] exp_q[$];
  logic [15:0] wlog[$];
  int          exp_err;
  int          exp_nsend;
  vec_t        vt[12];

  // Every table write seen, as {addr, data}.
  always @(negedge clk) if (tbl_we === 1'b1) wlog.push_back({tbl_addr, tbl_data});

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Slot rule from length classes: short codes use 7 low path bits; a code of
  // length L>=8 owns a block of 2^(14-L) slots ending below the previous one,
  // indexed by the top path bits ending at bit min(L,11).
  function automatic logic [7:0] ref_hash(input int len, input int path);
    int w, top, idx;
    if (len <= 7) return 8'(path % 128);
    w   = 14 - len;
    top = (len < 11) ? len : 11;
    idx = (path >> (top - w + 1)) % (1 << w);
    return 8'(256 - (1 << (w + 1)) + idx);
  endfunction

  function automatic void model();
    bit         occ[256];
    logic [7:0] a;
    exp_q.delete();
    exp_err   = 0;
    exp_nsend = ents.size();
    for (int i = 0; i < 256; i++) occ[i] = 1'b0;
    for (int i = 0; i < ents.size(); i++) begin
      if (ents[i].len == 0 || ents[i].len > 12) begin
        exp_err = 1; exp_nsend = i + 1; break;
      end
      a = ref_hash(int'(ents[i].len), int'(ents[i].path));
      if (occ[a]) begin
        exp_err = 2; exp_nsend = i + 1; break;
      end
      occ[a] = 1'b1;
      exp_q.push_back({a, ents[i].ch});
    end
  endfunction

  task automatic do_start(input int n);
    @(posedge clk); #1;
    num_entries = 9'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input ent_t e);
    bit hs;
    bit ok;
    in_valid = 1'b1; in_char = e.ch; in_length = e.len; in_path = e.path;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      if (hs) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
    if (!ok) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 400) begin @(negedge clk); n++; end
    if (!(done || error)) check("end_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic verify_end();
    int bad = 0;
    wait_end();
    check("done",      done,     exp_err == 0);
    check("error",     error,    exp_err != 0);
    check("err_code",  err_code, exp_err);
    check("busy_end",  busy,     0);
    check("ready_end", in_ready, 0);
    check("we_end",    tbl_we,   0);
    check("wr_count",  wlog.size(), 256 + exp_q.size());
    for (int i = 0; i < 256 && i < wlog.size(); i++)
      if (wlog[i] !== {i[7:0], 8'h00}) bad++;
    check("clear_writes_bad", bad, 0);
    for (int i = 0; i < exp_q.size(); i++)
      if (256 + i < wlog.size()) check("wr_addr_data", wlog[256 + i], exp_q[i]);
  endtask

  task automatic run_load(input bit gaps);
    wlog.delete();
    do_start(ents.size());
    for (int i = 0; i < exp_nsend; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(ents[i]);
    end
    verify_end();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_entries = '0;
    in_valid = 1'b1; in_char = 8'h55; in_length = 4'd3; in_path = 12'h001;

    vt[0]  = '{8'h41, 4'd3,  12'h005, 8'd5};
    vt[1]  = '{8'h42, 4'd8,  12'h0F8, 8'd159};
    vt[2]  = '{8'h43, 4'd1,  12'h07F, 8'd127};
    vt[3]  = '{8'h44, 4'd9,  12'h3E0, 8'd223};
    vt[4]  = '{8'h45, 4'd10, 12'h780, 8'd239};
    vt[5]  = '{8'h46, 4'd11, 12'hE00, 8'd247};
    vt[6]  = '{8'h47, 4'd12, 12'hC00, 8'd251};
    vt[7]  = '{8'h48, 4'd12, 12'h000, 8'd248};
    vt[8]  = '{8'h49, 4'd8,  12'h000, 8'd128};
    vt[9]  = '{8'h4A, 4'd7,  12'h080, 8'd0};
    vt[10] = '{8'h4B, 4'd11, 12'h1FF, 8'd240};
    vt[11] = '{8'h4C, 4'd9,  12'h01F, 8'd192};

    // Reset: all outputs low, in_valid ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {tbl_we, tbl_addr, tbl_data, busy, done, error, err_code, in_ready}, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_ready", in_ready, 0);
    check("idle_busy",  busy,     0);
    check("idle_no_wr", wlog.size(), 0);
    in_valid = 1'b0;

    // Two-entry load from the first table rows, then the whole table.
    for (int pass = 0; pass < 2; pass++) begin
      int n = (pass == 0) ? 2 : 12;
      ents.delete(); exp_q.delete();
      for (int i = 0; i < n; i++) begin
        ents.push_back('{vt[i].ch, vt[i].len, vt[i].path});
        exp_q.push_back({vt[i].exp_addr, vt[i].ch});
      end
      exp_err = 0; exp_nsend = n;
      run_load(1'b0);
    end

    // Back-to-back beats to slot 1: first written, second collides.
    ents.delete();
    ents.push_back('{8'h31, 4'd2, 12'h001});
    ents.push_back('{8'h32, 4'd5, 12'h001});
    exp_q.delete(); exp_q.push_back(16'h0131);
    exp_err = 2; exp_nsend = 2;
    run_load(1'b0);

    // Abort from ERROR clears status.
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_err_code", err_code, 0);
    check("abort_error",    error,    0);

    // Length 13: error, no write.
    ents.delete(); ents.push_back('{8'h5A, 4'd13, 12'h000});
    exp_q.delete(); exp_err = 1; exp_nsend = 1;
    run_load(1'b0);

    // Restart with zero entries: err_code cleared, DONE straight after wipe.
    wlog.delete();
    do_start(0);
    check("restart_err_code", err_code, 0);
    check("restart_busy",     busy,     1);
    ents.delete(); exp_q.delete(); exp_err = 0;
    verify_end();

    // Abort mid-wipe at address 100.
    begin
      bit hit = 1'b0;
      do_start(3);
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (tbl_we && tbl_addr == 8'd100) begin hit = 1'b1; break; end
      end
      check("abort_addr_reached", hit, 1);
      abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      check("abort_we",    tbl_we,   0);
      check("abort_busy",  busy,     0);
      check("abort_state", {done, error, in_ready}, 0);
      repeat (3) @(negedge clk);
      check("abort_stays", {tbl_we, busy}, 0);
    end

    // start pulsed mid-LOAD is ignored.
    wlog.delete();
    do_start(2);
    send('{8'h58, 4'd12, 12'hC00});
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("midload_busy", busy, 1);
    send('{8'h59, 4'd3, 12'h002});
    exp_q.delete(); exp_q.push_back({8'd251, 8'h58}); exp_q.push_back({8'd2, 8'h59});
    exp_err = 0;
    verify_end();

    // Random loads against the reference.
    for (int r = 0; r < 10; r++) begin
      ents.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
        ent_t e;
        int   l;
        if ($urandom_range(0, 7) == 0) begin
          l = int'($urandom_range(12, 15));
          if (l == 12) l = 0;
        end else begin
          l = int'($urandom_range(1, 12));
        end
        e.ch = 8'($urandom); e.len = 4'(l); e.path = 12'($urandom);
        ents.push_back(e);
      end
      model();
      run_load(1'b1);
    end

    // Reset mid-load returns everything to reset values.
    do_start(4);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", {tbl_we, tbl_addr, tbl_data, busy, done, error, err_code, in_ready}, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
